block_dma_ctrl: RTL and testbench
=================================

# block_dma_ctrl

Burst controller between a cache's block-miss/writeback port and `main_memory`. It accepts one whole-block read or write request and splits it into `block_width_p/dma_data_width_p` sequential beats of `dma_data_width_p` words on the memory bus. It collects the returned beats into a full block and signals completion to the cache with a one-cycle response pulse. There is one outstanding block request at a time; beats may be pipelined back-to-back toward memory.

## Interface
Parameters:
- `block_width_p`, default 8: cache block size in 32-bit words; power of two.
- `dma_data_width_p`, default 2: words per memory beat. Must be a power of two, ≤ `block_width_p`, and divide it.
- Derived: N = `block_width_p/dma_data_width_p` beats. Beat stride is `dma_data_width_p*4` bytes.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `reset_i`  in  1  synchronous, active-high reset.
- `req_valid_i`  in  1  cache request valid.
- `req_ready_o`  out  1  controller idle and able to accept a request.
- `req_we_i`  in  1  1 = block write, 0 = block read.
- `req_addr_i`  in  32  byte address; low log2(`block_width_p`)+2 bits are ignored.
- `req_wdata_i`  in  `block_width_p*32`  write block; word 0 is in bits [31:0].
- `resp_valid_o`  out  1  one-cycle completion pulse.
- `resp_data_o`  out  `block_width_p*32`  assembled block; word 0 is in bits [31:0].
- `mem_valid_o`  out  1  beat request to memory.
- `mem_ready_i`  in  1  memory accepts the beat.
- `mem_we_o`  out  1  beat is a write.
- `mem_addr_o`  out  32  beat byte address.
- `mem_wdata_o`  out  `dma_data_width_p*32`  beat write data.
- `mem_valid_i`  in  1  memory return beat valid; one return per accepted beat, reads and writes alike.
- `mem_data_i`  in  `dma_data_width_p*32`  return beat data.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - `req_ready_o` = 1.
  - On `req_valid_i`: latch `we`, base = `req_addr_i` with the block-offset bits cleared, and `req_wdata_i`.
  - Clear issue count `icnt` and response count `rcnt`, then go to ISSUE.
- **ISSUE**
  - `mem_valid_o` = 1, `mem_we_o` = latched `we`.
  - `mem_addr_o` = base + `icnt`·stride.
  - `mem_wdata_o` = latched words [`icnt`·D +: D], where D = `dma_data_width_p`.
  - On `mem_ready_i`, `icnt` increments. When beat N−1 is accepted, go to WAIT.
  - While `mem_ready_i` = 0, the address, data and `we` outputs are held stable.
- **Response collection (ISSUE and WAIT)**
  - Each `mem_valid_i` writes `mem_data_i` into block buffer words [`rcnt`·D +: D] and increments `rcnt`.
  - Capturing the N-th response moves to DONE.
  - This transition takes priority and occurs even from ISSUE; it is unreachable with a compliant memory but is defined anyway.
- **DONE**
  - `resp_valid_o` = 1 for exactly one cycle, then go to IDLE.
  - `resp_data_o` holds the buffer and stays stable until the next request's first return beat.
- **Writes:** `resp_data_o` carries whatever memory returned. With `main_memory`, that is the pre-write contents. The cache must treat it as don't-care.
- **Ignored inputs:**
  - `mem_valid_i` in IDLE or DONE.
  - `req_valid_i` outside IDLE. It is not latched; the cache holds it until `req_ready_o`.
- **Counter widths:** `icnt` and `rcnt` are log2(N)+1 bits, with no wrap inside a request. Address arithmetic is 32-bit unsigned; wrap at 2^32 is permitted.
- **N = 1:** ISSUE lasts a single accepted beat; behaviour is otherwise identical.
- **Reset:**
  - Any state goes to IDLE; counters clear; buffer and latched request clear to 0.
  - A memory return arriving the cycle after reset deasserts is dropped, because that cycle is in IDLE.

## Timing
- **Reset values:**
  - `req_ready_o` = 0 while `reset_i` = 1, and 1 on the first cycle after.
  - `mem_valid_o` = 0, `mem_we_o` = 0, `mem_addr_o` = 0, `mem_wdata_o` = 0.
  - `resp_valid_o` = 0, `resp_data_o` = 0.
- **Outputs in IDLE/WAIT/DONE:** `mem_valid_o` = 0, and `mem_addr_o`/`mem_wdata_o`/`mem_we_o` are driven 0.
- **Zero-stall schedule** (cycle 0 is the request handshake):
  - Beats issue on cycles 1..N.
  - Returns arrive on cycles 2..N+1.
  - `resp_valid_o` is high on cycle N+2.
  - `req_ready_o` is high on cycle N+3.
- **Stalls:** each cycle with `mem_ready_i` = 0 during ISSUE delays completion by one cycle.
- **Throughput:** at most one beat per cycle. Issue and return overlap; no bubble between beats.

## Test plan
- **Read burst, defaults.** Memory word i = i; request read at 0x40.
  - Beats at 0x40/0x48/0x50/0x58 on cycles 1–4.
  - `resp_valid_o` on cycle 6; `resp_data_o` words = 16..23.
  - `req_ready_o` on cycle 7.
- **Write then read.**
  - Write block 0xA0..0xA7 at 0x80: 4 beats with `mem_we_o` = 1, `mem_wdata_o` beat 1 = {0xA3, 0xA2}.
  - Read 0x80 returns 0xA0..0xA7.
- **Backpressure.** `mem_ready_i` low on cycles 2–3 of a read at 0x40.
  - `mem_addr_o` held at 0x48 through cycle 4.
  - `resp_valid_o` on cycle 8.
- **Unaligned address plus back-to-back requests.**
  - Request at 0x4C → first beat address 0x40.
  - A second request held from cycle 1 is accepted only on cycle 7.
- **Reset mid-burst.** Assert `reset_i` on cycle 3 of a read.
  - All outputs hit their reset values.
  - Next read at 0x00 completes normally with words 0..7; no stale beat is captured.
- **N = 1 configuration** (`block_width_p` = 2, `dma_data_width_p` = 2).
  - Read at 0x10: single beat on cycle 1; `resp_valid_o` on cycle 3 with words {5, 4}.

Source files
------------

// File: rtl/block_dma_ctrl.sv
// block_dma_ctrl: splits one cache block request into memory beats
// and reassembles the returned beats into a single block response.
module block_dma_ctrl #(
   parameter int block_width_p    = 8,
   parameter int dma_data_width_p = 2
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          req_valid_i,
   output logic                          req_ready_o,
   input  logic                          req_we_i,
   input  logic [31:0]                   req_addr_i,
   input  logic [block_width_p*32-1:0]   req_wdata_i,
   output logic                          resp_valid_o,
   output logic [block_width_p*32-1:0]   resp_data_o,
   output logic                          mem_valid_o,
   input  logic                          mem_ready_i,
   output logic                          mem_we_o,
   output logic [31:0]                   mem_addr_o,
   output logic [dma_data_width_p*32-1:0] mem_wdata_o,
   input  logic                          mem_valid_i,
   input  logic [dma_data_width_p*32-1:0] mem_data_i
);

   localparam int beats     = block_width_p / dma_data_width_p;
   localparam int cw        = $clog2(beats) + 1;
   localparam int beat_bits = dma_data_width_p * 32;
   localparam int blk_bits  = block_width_p * 32;
   localparam int stride_sh = $clog2(dma_data_width_p) + 2;
   localparam logic [cw-1:0]  last     = cw'(beats - 1);
   localparam logic [31:0]    off_mask = 32'(block_width_p * 4) - 32'd1;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } state_t;

   state_t                 state;
   state_t                 state_next;
   logic                   we;
   logic [31:0]            base;
   logic [blk_bits-1:0]    wbuf;
   logic [blk_bits-1:0]    rbuf;
   logic [cw-1:0]          icnt;
   logic [cw-1:0]          rcnt;
   logic [31:0]            beat_addr;
   logic [beat_bits-1:0]   beat_wdata;
   logic                   issue_fire;
   logic                   ret_fire;
   logic                   ret_last;

   assign issue_fire  = (state == ISSUE) && mem_ready_i;
   assign ret_fire    = ((state == ISSUE) || (state == WAIT)) && mem_valid_i;
   assign ret_last    = ret_fire && (rcnt == last);
   assign beat_addr   = base + (32'(icnt) << stride_sh);
   assign resp_data_o = rbuf;

   // select the write beat addressed by the issue counter
   always_comb begin
      beat_wdata = '0;
      for (int i = 0; i < beats; i++) begin
         if (icnt == cw'(i)) begin
            beat_wdata = wbuf[i*beat_bits +: beat_bits];
         end
      end
   end

   // state register
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // next state and outputs; a final return beat wins over issue
   always_comb begin
      state_next   = state;
      req_ready_o  = 1'b0;
      resp_valid_o = 1'b0;
      mem_valid_o  = 1'b0;
      mem_we_o     = 1'b0;
      mem_addr_o   = '0;
      mem_wdata_o  = '0;
      unique case (state)
         IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            mem_valid_o = 1'b1;
            mem_we_o    = we;
            mem_addr_o  = beat_addr;
            mem_wdata_o = beat_wdata;
            if (mem_ready_i && (icnt == last)) begin
               state_next = WAIT;
            end
            if (ret_last) begin
               state_next = DONE;
            end
         end
         WAIT: begin
            if (ret_last) begin
               state_next = DONE;
            end
         end
         DONE: begin
            resp_valid_o = 1'b1;
            state_next   = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (reset_i) begin
         req_ready_o  = 1'b0;
         resp_valid_o = 1'b0;
         mem_valid_o  = 1'b0;
         mem_we_o     = 1'b0;
         mem_addr_o   = '0;
         mem_wdata_o  = '0;
      end
   end

   // request latch, beat counters and return-beat assembly
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         we   <= 1'b0;
         base <= '0;
         wbuf <= '0;
         rbuf <= '0;
         icnt <= '0;
         rcnt <= '0;
      end else begin
         if ((state == IDLE) && req_valid_i) begin
            we   <= req_we_i;
            base <= req_addr_i & ~off_mask;
            wbuf <= req_wdata_i;
            icnt <= '0;
            rcnt <= '0;
         end
         if (issue_fire) begin
            icnt <= icnt + cw'(1);
         end
         if (ret_fire) begin
            for (int i = 0; i < beats; i++) begin
               if (rcnt == cw'(i)) begin
                  rbuf[i*beat_bits +: beat_bits] <= mem_data_i;
               end
            end
            rcnt <= rcnt + cw'(1);
         end
      end
   end

endmodule

// File: tb/tb_block_dma_ctrl.sv
// tb_block_dma_ctrl: scoreboard bench with a block-level memory model,
// directed timing cases and randomized back-to-back traffic.
module tb_block_dma_ctrl;

   localparam int BW   = 8;
   localparam int D    = 2;
   localparam int NB   = BW / D;
   localparam int BEAT = D * 32;
   localparam int BLK  = BW * 32;

   typedef struct {
      logic             we;
      logic [31:0]      addr;
      logic [BEAT-1:0]  wdata;
   } beat_t;

   logic            clk;
   logic            reset;
   logic            req_valid;
   logic            req_ready;
   logic            req_we;
   logic [31:0]     req_addr;
   logic [BLK-1:0]  req_wdata;
   logic            resp_valid;
   logic [BLK-1:0]  resp_data;
   logic            mem_valid_o;
   logic            mem_ready;
   logic            mem_we;
   logic [31:0]     mem_addr;
   logic [BEAT-1:0] mem_wdata;
   logic            mem_valid_i;
   logic [BEAT-1:0] mem_data;

   logic            r1_valid;
   logic            r1_ready;
   logic [31:0]     r1_addr;
   logic            p1_valid;
   logic [63:0]     p1_data;
   logic            m1_valid_o;
   logic            m1_we;
   logic [31:0]     m1_addr;
   logic [63:0]     m1_wdata;
   logic            m1_valid_i;
   logic [63:0]     m1_data;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   logic [31:0]     mem [0:255];
   logic [31:0]     ref_mem [0:255];
   beat_t           exp_beats [$];
   logic [BLK-1:0]  exp_resp [$];

   logic [31:0]     addr_log [0:1023];
   logic [BEAT-1:0] wdata_log [0:1023];
   bit              v_log [0:1023];
   bit              we_log [0:1023];
   bit              rdy_log [0:1023];

   int              last_resp_cyc = -1;
   logic [BLK-1:0]  last_resp_data;
   bit              rnd_stall = 0;
   int              sf = -1;
   int              st = -1;
   bit              inject_stale = 0;

   block_dma_ctrl #(.block_width_p(BW), .dma_data_width_p(D)) dut (
      .clk_i(clk), .reset_i(reset),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .resp_valid_o(resp_valid), .resp_data_o(resp_data),
      .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready),
      .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
      .mem_valid_i(mem_valid_i), .mem_data_i(mem_data)
   );

   block_dma_ctrl #(.block_width_p(2), .dma_data_width_p(2)) u1 (
      .clk_i(clk), .reset_i(reset),
      .req_valid_i(r1_valid), .req_ready_o(r1_ready),
      .req_we_i(1'b0), .req_addr_i(r1_addr), .req_wdata_i(64'h0),
      .resp_valid_o(p1_valid), .resp_data_o(p1_data),
      .mem_valid_o(m1_valid_o), .mem_ready_i(1'b1),
      .mem_we_o(m1_we), .mem_addr_o(m1_addr), .mem_wdata_o(m1_wdata),
      .mem_valid_i(m1_valid_i), .mem_data_i(m1_data)
   );

   function automatic void check(string nm, logic [255:0] act,
                                 logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h",
                  nm, cyc, act, exp);
      end
   endfunction

   function automatic int widx(logic [31:0] base, int w);
      return int'(((base >> 2) + 32'(w)) & 32'hFF);
   endfunction

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // memory ready: directed stall window plus optional random stalls
   initial begin
      mem_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         mem_ready = !(cyc >= sf && cyc <= st) &&
                     !(rnd_stall && $urandom_range(0, 3) == 0);
      end
   end

   // main memory: one return per accepted beat, one cycle later
   initial begin
      bit hs;
      logic [BEAT-1:0] rd;
      mem_valid_i = 1'b0;
      mem_data = '0;
      rd = '0;
      forever begin
         @(negedge clk);
         hs = mem_valid_o && mem_ready;
         if (hs) begin
            for (int j = 0; j < D; j++) begin
               rd[j*32 +: 32] = mem[widx(mem_addr, j)];
               if (mem_we) mem[widx(mem_addr, j)] = mem_wdata[j*32 +: 32];
            end
         end
         @(posedge clk);
         #1;
         mem_valid_i = hs || inject_stale;
         mem_data = hs ? rd : {D{32'hDEADBEEF}};
      end
   end

   // N=1 memory: word i holds i
   initial begin
      bit hs1;
      logic [31:0] a1;
      m1_valid_i = 1'b0;
      m1_data = '0;
      a1 = '0;
      forever begin
         @(negedge clk);
         hs1 = m1_valid_o;
         if (hs1) a1 = m1_addr;
         @(posedge clk);
         #1;
         m1_valid_i = hs1;
         m1_data = {(a1 >> 2) + 32'd1, a1 >> 2};
      end
   end

   // beat monitor: log, hold-under-stall, idle-zero and beat scoreboard
   initial begin
      bit pstall;
      beat_t pb;
      beat_t b;
      int k;
      pstall = 0;
      pb = '{1'b0, 32'h0, '0};
      forever begin
         @(negedge clk);
         k = cyc % 1024;
         addr_log[k] = mem_addr;
         wdata_log[k] = mem_wdata;
         v_log[k] = mem_valid_o;
         we_log[k] = mem_we;
         rdy_log[k] = req_ready;
         if (!reset) begin
            if (pstall) begin
               check("hold_valid", 256'(mem_valid_o), 256'(1));
               check("hold_beat", {mem_we, mem_addr, mem_wdata},
                     {pb.we, pb.addr, pb.wdata});
            end
            if (!mem_valid_o)
               check("idle_zero", {mem_we, mem_addr, mem_wdata}, 256'(0));
            if (mem_valid_o && mem_ready) begin
               if (exp_beats.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL beat_unexpected at cycle %0d: addr %0h",
                           cyc, mem_addr);
               end else begin
                  b = exp_beats.pop_front();
                  check("beat", {mem_we, mem_addr, mem_wdata},
                        {b.we, b.addr, b.wdata});
               end
            end
            pstall = mem_valid_o && !mem_ready;
            pb = '{mem_we, mem_addr, mem_wdata};
         end else begin
            pstall = 0;
         end
      end
   end

   // response monitor
   initial begin
      forever begin
         @(negedge clk);
         if (resp_valid) begin
            last_resp_cyc = cyc;
            last_resp_data = resp_data;
            if (exp_resp.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL resp_unexpected at cycle %0d: data %0h",
                        cyc, resp_data);
            end else begin
               check("resp_data", resp_data, exp_resp.pop_front());
            end
         end
      end
   end

   // issue a request; expectations come from whole-block semantics
   task automatic do_req(input bit we, input logic [31:0] addr,
                         input logic [BLK-1:0] wd, output int c0);
      logic [31:0] base;
      logic [BLK-1:0] blk;
      beat_t b;
      int n;
      req_valid = 1'b1;
      req_we = we;
      req_addr = addr;
      req_wdata = wd;
      c0 = -1;
      n = 0;
      while (c0 < 0 && n < 300) begin
         @(negedge clk);
         if (req_ready) c0 = cyc;
         n++;
      end
      if (c0 < 0) begin
         checks++;
         errors++;
         $display("FAIL req_accept: no ready in 300 cycles, got 0 need 1");
      end else begin
         base = addr & ~32'(BW * 4 - 1);
         for (int w = 0; w < BW; w++) begin
            blk[w*32 +: 32] = ref_mem[widx(base, w)];
            if (we) ref_mem[widx(base, w)] = wd[w*32 +: 32];
         end
         exp_resp.push_back(blk);
         for (int i = 0; i < NB; i++) begin
            b.we = we;
            b.addr = base + 32'(i * D * 4);
            b.wdata = wd[i*BEAT +: BEAT];
            exp_beats.push_back(b);
         end
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(exp_resp.size() == 0 && req_ready) && n < 500);
      if (n >= 500) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: pending %0d, need 0", exp_resp.size());
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int c0;
      int c1;
      logic [BLK-1:0] wblk;
      int t1;
      int b1;
      logic [31:0] ba1;
      for (int i = 0; i < 256; i++) begin
         mem[i] = 32'(i);
         ref_mem[i] = 32'(i);
      end
      reset = 1'b1;
      req_valid = 1'b0;
      req_we = 1'b0;
      req_addr = '0;
      req_wdata = '0;
      r1_valid = 1'b0;
      r1_addr = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 256'(req_ready), 256'(0));
      check("rst_mem", {mem_valid_o, mem_we, mem_addr, mem_wdata}, 256'(0));
      check("rst_resp_valid", 256'(resp_valid), 256'(0));
      check("rst_resp_data", resp_data, 256'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("ready_after_rst", 256'(req_ready), 256'(1));
      @(posedge clk);
      #1;

      // read burst at 0x40
      do_req(1'b0, 32'h40, '0, c0);
      wait_idle();
      for (int i = 0; i < NB; i++) begin
         check("rd_beat_valid", 256'(v_log[(c0 + 1 + i) % 1024]), 256'(1));
         check("rd_beat_addr", 256'(addr_log[(c0 + 1 + i) % 1024]),
               256'(32'h40 + 32'(8 * i)));
      end
      check("rd_resp_cycle", 256'(last_resp_cyc - c0), 256'(6));
      check("rd_ready_c6", 256'(rdy_log[(c0 + 6) % 1024]), 256'(0));
      check("rd_ready_c7", 256'(rdy_log[(c0 + 7) % 1024]), 256'(1));
      check("rd_word0", 256'(last_resp_data[31:0]), 256'(16));
      check("rd_word7", 256'(last_resp_data[255:224]), 256'(23));

      // write then read at 0x80
      for (int w = 0; w < BW; w++) wblk[w*32 +: 32] = 32'hA0 + 32'(w);
      do_req(1'b1, 32'h80, wblk, c0);
      wait_idle();
      check("wr_we", 256'(we_log[(c0 + 1) % 1024]), 256'(1));
      check("wr_beat1_data", 256'(wdata_log[(c0 + 2) % 1024]),
            {192'h0, 32'hA3, 32'hA2});
      do_req(1'b0, 32'h80, '0, c0);
      wait_idle();
      check("rd_after_wr", last_resp_data, wblk);

      // backpressure on cycles 2-3
      do_req(1'b0, 32'h40, '0, c0);
      sf = c0 + 2;
      st = c0 + 3;
      wait_idle();
      sf = -1;
      st = -1;
      for (int i = 2; i <= 4; i++)
         check("bp_addr_hold", 256'(addr_log[(c0 + i) % 1024]), 256'(32'h48));
      check("bp_resp_cycle", 256'(last_resp_cyc - c0), 256'(8));

      // unaligned address and back-to-back requests
      do_req(1'b0, 32'h4C, '0, c0);
      do_req(1'b0, 32'h100, '0, c1);
      check("unal_addr", 256'(addr_log[(c0 + 1) % 1024]), 256'(32'h40));
      check("b2b_accept", 256'(c1 - c0), 256'(7));
      wait_idle();

      // reset mid-burst, then a stale return the cycle after reset
      do_req(1'b0, 32'h40, '0, c0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      exp_beats.delete();
      exp_resp.delete();
      @(negedge clk);
      check("mid_rst_ready", 256'(req_ready), 256'(0));
      check("mid_rst_mem", {mem_valid_o, mem_we, mem_addr, mem_wdata},
            256'(0));
      check("mid_rst_resp", 256'(resp_valid), 256'(0));
      @(posedge clk);
      #1;
      @(negedge clk);
      check("mid_rst_data", resp_data, 256'(0));
      inject_stale = 1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      inject_stale = 0;
      check("post_rst_ready", 256'(req_ready), 256'(1));
      @(posedge clk);
      #1;
      do_req(1'b0, 32'h0, '0, c0);
      wait_idle();
      check("post_rst_word0", 256'(last_resp_data[31:0]), 256'(0));
      check("post_rst_word7", 256'(last_resp_data[255:224]), 256'(7));

      // randomized traffic with random stalls
      rnd_stall = 1;
      for (int r = 0; r < 24; r++) begin
         for (int w = 0; w < BW; w++) wblk[w*32 +: 32] = $urandom;
         do_req(1'(($urandom_range(0, 1))), 32'($urandom_range(0, 1023)),
                wblk, c0);
      end
      rnd_stall = 0;
      wait_idle();

      // N=1 configuration
      r1_valid = 1'b1;
      r1_addr = 32'h10;
      c0 = -1;
      for (int n = 0; n < 20 && c0 < 0; n++) begin
         @(negedge clk);
         if (r1_ready) c0 = cyc;
      end
      @(posedge clk);
      #1;
      r1_valid = 1'b0;
      t1 = -1;
      b1 = -1;
      ba1 = '0;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         if (m1_valid_o && b1 < 0) begin
            b1 = cyc;
            ba1 = m1_addr;
         end
         if (p1_valid && t1 < 0) begin
            t1 = cyc;
            check("n1_data", 256'(p1_data), {192'h0, 32'd5, 32'd4});
         end
      end
      check("n1_beat_cycle", 256'(b1 - c0), 256'(1));
      check("n1_beat_addr", 256'(ba1), 256'(32'h10));
      check("n1_resp_cycle", 256'(t1 - c0), 256'(3));

      check("beats_drained", 256'(exp_beats.size()), 256'(0));
      check("resps_drained", 256'(exp_resp.size()), 256'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
